// File: rtl/exc_pkg.sv
// exc_pkg: shared types and constants for the exception sequencer.
//   state_t         sequencer states
//   ESR_*           exception syndrome codes
//   EXC_VECTOR_DFLT default handler entry address
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TAKE,
        RETURN,
        HALT
    } state_t;

    localparam logic [3:0] ESR_NONE  = 4'b0000;
    localparam logic [3:0] ESR_INVOP = 4'b0001;
    localparam logic [3:0] ESR_IRQ   = 4'b0010;

    localparam logic [63:0] EXC_VECTOR_DFLT = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/exception_ctrl.sv
// exception_ctrl: exception/interrupt sequencer for the pipelined LEGv8 core.
// Samples invalid-opcode, ERET and external IRQ at decode, captures the
// return address and cause, then flushes the front end and redirects fetch.
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   ExtIRQ       in   level interrupt request
//   id_valid     in   ID holds a real instruction
//   id_pc        in   PC of the instruction in ID
//   id_invop     in   ID decoded an invalid opcode
//   id_eret      in   ID decoded ERET
//   flush        out  kill IF/ID and ID/EX at the next edge
//   pc_redirect  out  next PC := pc_target
//   pc_target    out  redirect address
//   ELR          out  exception link register
//   ESR          out  exception syndrome
//   exc_active   out  handler running, IRQs masked
//   halt         out  fatal double fault
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned  N          = 64,
    parameter logic [N-1:0] EXC_VECTOR = EXC_VECTOR_DFLT[N-1:0]
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         ExtIRQ,
    input  logic         id_valid,
    input  logic [N-1:0] id_pc,
    input  logic         id_invop,
    input  logic         id_eret,
    output logic         flush,
    output logic         pc_redirect,
    output logic [N-1:0] pc_target,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic         exc_active,
    output logic         halt
);

    state_t state, state_nxt;
    logic   irq_pend;
    logic   take_invop;
    logic   take_irq;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            irq_pend   <= 1'b0;
            exc_active <= 1'b0;
            ELR        <= '0;
            ESR        <= ESR_NONE;
        end else begin
            state <= state_nxt;

            // A level still high at the take edge re-arms the request,
            // so set has priority over the clear.
            if (ExtIRQ)
                irq_pend <= 1'b1;
            else if (take_irq)
                irq_pend <= 1'b0;

            if (take_invop) begin
                ELR <= id_pc;
                ESR <= ESR_INVOP;
            end else if (take_irq) begin
                ELR <= id_pc;
                ESR <= ESR_IRQ;
            end

            if (state == TAKE)
                exc_active <= 1'b1;
            else if (state == RETURN) begin
                exc_active <= 1'b0;
                ESR        <= ESR_NONE;
            end
        end
    end

    // Next state plus Moore outputs; outputs depend only on registered state.
    always_comb begin
        state_nxt   = state;
        take_invop  = 1'b0;
        take_irq    = 1'b0;
        flush       = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        halt        = 1'b0;

        unique case (state)
            IDLE: begin
                if (id_valid && id_invop && exc_active) begin
                    state_nxt = HALT;
                end else if (id_valid && id_invop) begin
                    state_nxt  = TAKE;
                    take_invop = 1'b1;
                end else if (id_valid && id_eret && exc_active) begin
                    state_nxt = RETURN;
                end else if (id_valid && irq_pend && !exc_active) begin
                    state_nxt = TAKE;
                    take_irq  = 1'b1;
                end
            end
            TAKE: begin
                state_nxt   = IDLE;
                flush       = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = EXC_VECTOR;
            end
            RETURN: begin
                state_nxt   = IDLE;
                flush       = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = ELR;
            end
            HALT: begin
                state_nxt = HALT;
                flush     = 1'b1;
                halt      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed self-checking bench for exception_ctrl.
// Inputs are driven 1 ns after each rising edge and outputs checked at the
// same point, so each check reflects the state entered at that edge.
module tb_exception_ctrl;

    localparam int unsigned N = 64;

    logic         CLOCK_50 = 1'b0;
    logic         reset;
    logic         ExtIRQ;
    logic         id_valid;
    logic [N-1:0] id_pc;
    logic         id_invop;
    logic         id_eret;
    logic         flush;
    logic         pc_redirect;
    logic [N-1:0] pc_target;
    logic [N-1:0] ELR;
    logic [3:0]   ESR;
    logic         exc_active;
    logic         halt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    exception_ctrl #(.N(N), .EXC_VECTOR(64'hD8)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .ExtIRQ     (ExtIRQ),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_invop   (id_invop),
        .id_eret    (id_eret),
        .flush      (flush),
        .pc_redirect(pc_redirect),
        .pc_target  (pc_target),
        .ELR        (ELR),
        .ESR        (ESR),
        .exc_active (exc_active),
        .halt       (halt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic inv,
                         input logic er, input logic irq);
        id_valid = v;
        id_pc    = pc;
        id_invop = inv;
        id_eret  = er;
        ExtIRQ   = irq;
    endtask

    // Expected: flush, pc_redirect, pc_target, ELR, ESR, exc_active, halt
    task automatic expect_out(input string tag, input logic f, input logic r,
                              input logic [63:0] tgt, input logic [63:0] elr,
                              input logic [3:0] esr, input logic act, input logic h);
        check({tag, ".flush"},  {63'd0, flush},       {63'd0, f});
        check({tag, ".redir"},  {63'd0, pc_redirect}, {63'd0, r});
        check({tag, ".target"}, pc_target,            tgt);
        check({tag, ".ELR"},    ELR,                  elr);
        check({tag, ".ESR"},    {60'd0, ESR},         {60'd0, esr});
        check({tag, ".active"}, {63'd0, exc_active},  {63'd0, act});
        check({tag, ".halt"},   {63'd0, halt},        {63'd0, h});
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 64'h0, 0, 0, 0);
        #12;
        expect_out("reset", 0, 0, 64'h0, 64'h0, 4'h0, 0, 0);
        reset = 1'b0;
        tick();

        // Invalid opcode from reset
        drive(1, 64'h40, 1, 0, 0); tick();
        expect_out("invop_take", 1, 1, 64'hD8, 64'h40, 4'h1, 0, 0);
        drive(0, 64'h0, 0, 0, 0); tick();
        expect_out("invop_idle", 0, 0, 64'h0, 64'h40, 4'h1, 1, 0);

        // ERET back
        drive(1, 64'h44, 0, 1, 0); tick();
        expect_out("eret1_ret", 1, 1, 64'h40, 64'h40, 4'h1, 1, 0);
        drive(0, 64'h0, 0, 0, 0); tick();
        expect_out("eret1_idle", 0, 0, 64'h0, 64'h40, 4'h0, 0, 0);

        // IRQ pulse: taken two edges after the pulse edge
        drive(1, 64'h20, 0, 0, 1); tick();
        expect_out("irq_wait", 0, 0, 64'h0, 64'h40, 4'h0, 0, 0);
        drive(1, 64'h20, 0, 0, 0); tick();
        expect_out("irq_take", 1, 1, 64'hD8, 64'h20, 4'h2, 0, 0);
        drive(1, 64'h24, 0, 0, 0); tick();
        expect_out("irq_idle", 0, 0, 64'h0, 64'h20, 4'h2, 1, 0);
        tick();
        expect_out("irq_cleared", 0, 0, 64'h0, 64'h20, 4'h2, 1, 0);

        // Masked IRQ during handler, then ERET, then IRQ taken
        drive(1, 64'h28, 0, 0, 1); tick();
        drive(1, 64'h2C, 0, 0, 0); tick();
        expect_out("masked", 0, 0, 64'h0, 64'h20, 4'h2, 1, 0);
        drive(1, 64'h30, 0, 1, 0); tick();
        expect_out("eret2_ret", 1, 1, 64'h20, 64'h20, 4'h2, 1, 0);
        drive(1, 64'h34, 0, 0, 0); tick();
        expect_out("eret2_idle", 0, 0, 64'h0, 64'h20, 4'h0, 0, 0);
        tick();
        expect_out("irq2_take", 1, 1, 64'hD8, 64'h34, 4'h2, 0, 0);
        drive(0, 64'h0, 0, 0, 0); tick();
        drive(1, 64'h38, 0, 1, 0); tick();
        expect_out("eret3_ret", 1, 1, 64'h34, 64'h34, 4'h2, 1, 0);
        drive(0, 64'h0, 0, 0, 0); tick();
        expect_out("eret3_idle", 0, 0, 64'h0, 64'h34, 4'h0, 0, 0);

        // Priority: invop beats pending IRQ, IRQ survives until after ERET
        drive(0, 64'h0, 0, 0, 1); tick();
        drive(1, 64'h50, 1, 0, 0); tick();
        expect_out("prio_take", 1, 1, 64'hD8, 64'h50, 4'h1, 0, 0);
        drive(1, 64'h54, 0, 0, 0); tick();
        tick();
        expect_out("prio_masked", 0, 0, 64'h0, 64'h50, 4'h1, 1, 0);
        drive(1, 64'h58, 0, 1, 0); tick();
        expect_out("prio_ret", 1, 1, 64'h50, 64'h50, 4'h1, 1, 0);
        drive(0, 64'h0, 0, 0, 0); tick();
        drive(1, 64'h60, 0, 0, 0); tick();
        expect_out("prio_irq", 1, 1, 64'hD8, 64'h60, 4'h2, 0, 0);
        drive(0, 64'h0, 0, 0, 0); tick();
        expect_out("prio_idle", 0, 0, 64'h0, 64'h60, 4'h2, 1, 0);

        // Double fault
        drive(1, 64'h70, 1, 0, 0); tick();
        expect_out("halt", 1, 0, 64'h0, 64'h60, 4'h2, 1, 1);
        drive(1, 64'h74, 0, 1, 1); tick(); tick();
        expect_out("halt_held", 1, 0, 64'h0, 64'h60, 4'h2, 1, 1);
        #2 reset = 1'b1;
        #1;
        expect_out("halt_reset", 0, 0, 64'h0, 64'h0, 4'h0, 0, 0);
        drive(0, 64'h0, 0, 0, 0);
        tick();
        reset = 1'b0;

        // Stray ERET is a no-op
        drive(1, 64'h80, 0, 1, 0); tick();
        expect_out("stray_eret", 0, 0, 64'h0, 64'h0, 4'h0, 0, 0);

        // Reset during TAKE
        drive(1, 64'h90, 1, 0, 0); tick();
        expect_out("pre_reset_take", 1, 1, 64'hD8, 64'h90, 4'h1, 0, 0);
        drive(0, 64'h0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        expect_out("take_reset", 0, 0, 64'h0, 64'h0, 4'h0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        expect_out("post_reset", 0, 0, 64'h0, 64'h0, 4'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
